// File: rtl/simon_pkg.sv
// Shared definitions for the Simon Says datapath.
//   - colour codes carried on PlayerSelection[1:0]
//   - bit position of the valid strobe in PlayerSelection
//   - state encoding of the player-input capture FSM
//   - one-hot to colour-code helper
package simon_pkg;

  localparam logic [1:0] COL_RED    = 2'b00;
  localparam logic [1:0] COL_GREEN  = 2'b01;
  localparam logic [1:0] COL_BLUE   = 2'b10;
  localparam logic [1:0] COL_YELLOW = 2'b11;

  localparam int SEL_VALID = 2;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESSED      = 2'b01,
    WAIT_RELEASE = 2'b10
  } cap_state_e;

  // Only meaningful for a one-hot input; the caller guarantees that.
  function automatic logic [1:0] onehot_to_col(input logic [3:0] oh);
    logic [1:0] col;
    col = COL_RED;
    unique case (oh)
      4'b0001: col = COL_RED;
      4'b0010: col = COL_GREEN;
      4'b0100: col = COL_BLUE;
      4'b1000: col = COL_YELLOW;
      default: col = COL_RED;
    endcase
    return col;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchroniser plus stability-counter debouncer for a bus of raw buttons.
//   clk      : system clock
//   reset_n  : asynchronous active-low reset, synchronous release
//   din      : raw asynchronous inputs (1 = pressed)
//   dout     : debounced value; powers up as all-ones so that nothing is
//              taken as a press until a full release has been observed
// The whole bus is debounced as one word: any bit changing restarts the
// stability count, so dout only ever moves to a value that every bit agreed
// on for DEBOUNCE_CYCLES consecutive cycles.
module button_debounce #(
  parameter int DATA_W          = 4,
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [DATA_W-1:0] sync1_q, sync1_d;
  logic [DATA_W-1:0] sync2_q, sync2_d;
  logic [DATA_W-1:0] cand_q,  cand_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic [DATA_W-1:0] deb_q,   deb_d;

  always_comb begin
    sync1_d = din;
    sync2_d = sync1_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    deb_d   = deb_q;
    if (sync2_q != cand_q) begin
      cand_d = sync2_q;
      cnt_d  = '0;
    end else if (cnt_q == CNT_MAX) begin
      // Counter saturates here; the debounced value keeps being refreshed
      // with the same candidate, which is harmless.
      deb_d = cand_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      cand_q  <= '1;
      cnt_q   <= '0;
      deb_q   <= '1;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      deb_q   <= deb_d;
    end
  end

  assign dout = deb_q;

endmodule

// File: rtl/button_capture.sv
// Player-input capture for Simon Says: debounces the four colour buttons
// and turns each clean single-button press into a one-cycle selection.
//   clk             : system clock
//   reset_n         : asynchronous active-low reset, synchronous release
//   Buttons[3:0]    : raw push-buttons, bit i = colour code i
//   Enable          : presses are accepted only while high
//   PlayerSelection : [2] one-cycle valid strobe, [1:0] last accepted colour
//   MultiPress      : one-cycle pulse when a multi-button press is rejected
module button_capture
  import simon_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [3:0] Buttons,
  input  logic       Enable,
  output logic [2:0] PlayerSelection,
  output logic       MultiPress
);

  logic [3:0] deb;

  button_debounce #(
    .DATA_W          (4),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (Buttons),
    .dout    (deb)
  );

  cap_state_e state_q, state_d;
  logic [2:0] sel_q,   sel_d;
  logic       multi_q, multi_d;

  // Only IDLE can accept or reject; both other states just wait for the
  // debounced buttons to read all-released.
  always_comb begin
    state_d          = state_q;
    sel_d            = sel_q;
    sel_d[SEL_VALID] = 1'b0;
    multi_d          = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (deb == 4'b0000) begin
          state_d = IDLE;
        end else if ($onehot(deb)) begin
          if (Enable) begin
            sel_d   = {1'b1, onehot_to_col(deb)};
            state_d = PRESSED;
          end else begin
            state_d = WAIT_RELEASE;
          end
        end else begin
          multi_d = 1'b1;
          state_d = WAIT_RELEASE;
        end
      end
      PRESSED, WAIT_RELEASE: begin
        if (deb == 4'b0000) state_d = IDLE;
      end
      default: state_d = WAIT_RELEASE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= WAIT_RELEASE;
      sel_q   <= 3'b000;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      multi_q <= multi_d;
    end
  end

  assign PlayerSelection = sel_q;
  assign MultiPress      = multi_q;

endmodule

// File: tb/tb_button_capture.sv
// Bench for button_capture with a short debounce window.
module tb_button_capture;

  localparam int DC = 4;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [3:0] buttons = 4'b0000;
  logic       enable  = 1'b0;
  logic [2:0] ps;
  logic       mp;

  always #5 clk = ~clk;

  button_capture #(.DEBOUNCE_CYCLES(DC)) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .Buttons         (buttons),
    .Enable          (enable),
    .PlayerSelection (ps),
    .MultiPress      (mp)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Debounced value = the synchronised sample once the last DC+1 synchronised
  // samples since reset all agree; synchronised sample = raw input two edges
  // earlier (zero right after reset). A press is judged once per "armed"
  // period, an armed period starting whenever the debounced value reads 0.
  logic [3:0] smp[$];
  logic [3:0] m_d     = 4'hF;
  bit         m_armed = 1'b0;
  logic [2:0] m_sel   = 3'b000;
  logic       m_mp    = 1'b0;

  function automatic logic [1:0] col_of(input logic [3:0] v);
    logic [1:0] c;
    c = 2'b00;
    for (int i = 0; i < 4; i++) if (v[i]) c = 2'(i);
    return c;
  endfunction

  initial begin
    smp = '{4'b0, 4'b0};
    forever begin
      @(posedge clk or negedge reset_n);
      if (!reset_n) begin
        smp     = '{4'b0, 4'b0};
        m_d     = 4'hF;
        m_armed = 1'b0;
        m_sel   = 3'b000;
        m_mp    = 1'b0;
      end else begin
        bit same;
        m_mp     = 1'b0;
        m_sel[2] = 1'b0;
        if (m_d == 4'b0000) begin
          m_armed = 1'b1;
        end else if (m_armed) begin
          m_armed = 1'b0;
          if ($onehot(m_d)) begin
            if (enable) m_sel = {1'b1, col_of(m_d)};
          end else begin
            m_mp = 1'b1;
          end
        end
        smp.push_back(buttons);
        if (smp.size() > DC + 3) void'(smp.pop_front());
        if (smp.size() == DC + 3) begin
          same = 1'b1;
          for (int i = 1; i <= DC; i++) if (smp[i] != smp[0]) same = 1'b0;
          if (same) m_d = smp[DC];
        end
      end
    end
  end

  // ---------------- per-cycle comparison ----------------
  int         dut_strobes = 0;
  int         dut_multi   = 0;
  logic [2:0] last_val    = 3'b000;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("sel", 32'(ps), 32'(m_sel));
      check("multi", 32'(mp), 32'(m_mp));
      if (ps[2] === 1'b1) begin
        dut_strobes++;
        last_val = ps;
      end
      if (mp === 1'b1) dut_multi++;
    end
  end

  // ---------------- stimulus ----------------
  task automatic hold(input logic [3:0] b, input int n);
    @(negedge clk);
    buttons = b;
    repeat (n) @(posedge clk);
  endtask

  // Applies b, waits for its sampling edge, then counts edges to the strobe.
  task automatic measure_latency(input string tag, input logic [3:0] b,
                                 input logic [2:0] exp_val);
    int edges;
    @(negedge clk);
    buttons = b;
    @(posedge clk);
    edges = 0;
    while (edges < 30) begin
      @(posedge clk);
      #1;
      edges++;
      if (ps[2] === 1'b1) break;
    end
    check({tag, "_latency"}, 32'(edges), 32'(DC + 3));
    check({tag, "_value"}, 32'(ps), 32'(exp_val));
    @(posedge clk);
    #1;
    check({tag, "_cleared"}, 32'(ps), 32'({1'b0, exp_val[1:0]}));
  endtask

  int s0, m0;

  initial begin
    // 1: reset state and basic press
    repeat (3) @(posedge clk);
    #1;
    check("reset_sel", 32'(ps), 32'd0);
    check("reset_multi", 32'(mp), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    hold(4'b0000, 10);
    enable = 1'b1;
    s0 = dut_strobes; m0 = dut_multi;
    measure_latency("t1", 4'b0100, 3'b110);
    hold(4'b0100, 12);
    @(negedge clk);
    check("t1_strobes", 32'(dut_strobes - s0), 32'd1);
    check("t1_multi", 32'(dut_multi - m0), 32'd0);

    // 2: bouncing button 0
    hold(4'b0000, 10);
    s0 = dut_strobes;
    for (int i = 0; i < 6; i++) hold({3'b000, ~buttons[0]}, 2);
    @(negedge clk);
    check("t2_bounce", 32'(dut_strobes - s0), 32'd0);
    measure_latency("t2", 4'b0001, 3'b100);
    hold(4'b0001, 10);
    @(negedge clk);
    check("t2_strobes", 32'(dut_strobes - s0), 32'd1);

    // 3: simultaneous press rejected
    hold(4'b0000, 10);
    s0 = dut_strobes; m0 = dut_multi;
    hold(4'b0011, 15);
    @(negedge clk);
    check("t3_multi", 32'(dut_multi - m0), 32'd1);
    check("t3_nostrobe", 32'(dut_strobes - s0), 32'd0);
    hold(4'b0001, 15);
    @(negedge clk);
    check("t3_partial", 32'(dut_strobes - s0), 32'd0);
    hold(4'b0000, 10);
    hold(4'b0001, 15);
    @(negedge clk);
    check("t3_repress", 32'(dut_strobes - s0), 32'd1);
    check("t3_value", 32'(last_val), 32'(3'b100));

    // 4: Enable low blocks a press
    hold(4'b0000, 10);
    enable = 1'b0;
    s0 = dut_strobes;
    hold(4'b1000, 15);
    @(negedge clk);
    check("t4_disabled", 32'(dut_strobes - s0), 32'd0);
    hold(4'b0000, 10);
    enable = 1'b1;
    hold(4'b1000, 15);
    @(negedge clk);
    check("t4_enabled", 32'(dut_strobes - s0), 32'd1);
    check("t4_value", 32'(last_val), 32'(3'b111));

    // 5: button held through reset
    hold(4'b0000, 10);
    hold(4'b0010, 15);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    s0 = dut_strobes;
    hold(4'b0010, 20);
    @(negedge clk);
    check("t5_held", 32'(dut_strobes - s0), 32'd0);
    hold(4'b0000, 10);
    hold(4'b0010, 15);
    @(negedge clk);
    check("t5_repress", 32'(dut_strobes - s0), 32'd1);
    check("t5_value", 32'(last_val), 32'(3'b101));

    // 6: extra button while pressed, then reset inside a strobe cycle
    hold(4'b0000, 10);
    s0 = dut_strobes; m0 = dut_multi;
    hold(4'b0001, 15);
    hold(4'b0101, 15);
    @(negedge clk);
    check("t6_strobes", 32'(dut_strobes - s0), 32'd1);
    check("t6_multi", 32'(dut_multi - m0), 32'd0);
    hold(4'b0000, 10);
    @(negedge clk);
    buttons = 4'b1000;
    begin
      int n;
      n = 0;
      while (n < 30) begin
        @(posedge clk);
        #1;
        n++;
        if (ps[2] === 1'b1) break;
      end
      check("t6_strobe_seen", 32'(ps[2]), 32'd1);
      #1;
      reset_n = 1'b0;
      #1;
      check("t6_reset_sel", 32'(ps), 32'd0);
    end
    @(negedge clk);
    buttons = 4'b0000;
    @(negedge clk);
    reset_n = 1'b1;

    // random traffic against the model
    for (int k = 0; k < 80; k++) begin
      logic [3:0] b;
      int r;
      r = $urandom_range(0, 9);
      if (r < 5)      b = 4'b0001 << $urandom_range(0, 3);
      else if (r < 7) b = 4'b0000;
      else            b = 4'($urandom_range(0, 15));
      enable = ($urandom_range(0, 3) != 0);
      hold(b, $urandom_range(1, 12));
    end
    hold(4'b0000, 12);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
